// File: rtl/rng_pkg.sv
// Shared definitions for the multi-lane xorshift generator: shift triples,
// lane salt, FSM encoding and a width-generic reference step.
package rng_pkg;

  typedef enum logic {FILL = 1'b0, VALID = 1'b1} fsm_e;

  localparam logic [63:0] RNG_SALT = 64'h9E37_79B9_7F4A_7C15;

  localparam int XS16_A = 7;
  localparam int XS16_B = 9;
  localparam int XS16_C = 8;
  localparam int XS32_A = 13;
  localparam int XS32_B = 17;
  localparam int XS32_C = 5;
  localparam int XS64_A = 13;
  localparam int XS64_B = 7;
  localparam int XS64_C = 17;

  function automatic int xs_sh_a(input int width);
    case (width)
      16:      return XS16_A;
      64:      return XS64_A;
      default: return XS32_A;
    endcase
  endfunction

  function automatic int xs_sh_b(input int width);
    case (width)
      16:      return XS16_B;
      64:      return XS64_B;
      default: return XS32_B;
    endcase
  endfunction

  function automatic int xs_sh_c(input int width);
    case (width)
      16:      return XS16_C;
      64:      return XS64_C;
      default: return XS32_C;
    endcase
  endfunction

  // Reference step on a 64-bit container; bits above width are kept clear.
  function automatic logic [63:0] xs_step(input logic [63:0] state, input int width);
    logic [63:0] m;
    logic [63:0] x;
    m = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    x = state & m;
    x = (x ^ (x << xs_sh_a(width))) & m;
    x = x ^ (x >> xs_sh_b(width));
    x = (x ^ (x << xs_sh_c(width))) & m;
    return x;
  endfunction

endpackage

// File: rtl/xorshift_step.sv
// Combinational xorshift next-state for one lane; shift triple chosen by STATE_W.
module xorshift_step
  import rng_pkg::*;
#(
  parameter int STATE_W = 32
) (
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] next_o
);

  localparam int SH_A = xs_sh_a(STATE_W);
  localparam int SH_B = xs_sh_b(STATE_W);
  localparam int SH_C = xs_sh_c(STATE_W);

  logic [STATE_W-1:0] t1;
  logic [STATE_W-1:0] t2;

  always_comb begin
    t1     = state_i ^ (state_i << SH_A);
    t2     = t1 ^ (t1 >> SH_B);
    next_o = t2 ^ (t2 << SH_C);
  end

endmodule

// File: rtl/xorshift_rng_array.sv
// NUM_LANES independent xorshift streams sharing one valid/ready output stage.
// A word set is held until accepted; generation stalls rather than drops words.
module xorshift_rng_array
  import rng_pkg::*;
#(
  parameter int          STATE_W   = 32,
  parameter int          OUT_W     = 8,
  parameter int          NUM_LANES = 1,
  parameter logic [63:0] SEED      = 64'h1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       seed_load,
  input  logic [STATE_W-1:0]         seed_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_LANES*OUT_W-1:0] rand_out,
  output logic [31:0]                gen_count
);

  if (!(STATE_W == 16 || STATE_W == 32 || STATE_W == 64)) begin : g_bad_state_w
    $error("xorshift_rng_array: STATE_W must be 16, 32 or 64");
  end
  if (OUT_W < 1 || OUT_W > STATE_W) begin : g_bad_out_w
    $error("xorshift_rng_array: OUT_W must be 1..STATE_W");
  end
  if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
    $error("xorshift_rng_array: NUM_LANES must be 1..16");
  end

  logic [NUM_LANES-1:0][STATE_W-1:0] lane_q, lane_d;
  logic [NUM_LANES-1:0][STATE_W-1:0] lane_nxt;
  logic [NUM_LANES-1:0][STATE_W-1:0] load_seed;
  logic [NUM_LANES-1:0][STATE_W-1:0] reset_seed;
  logic [NUM_LANES-1:0][OUT_W-1:0]   word_nxt;
  logic [NUM_LANES-1:0][OUT_W-1:0]   rand_q, rand_d;
  logic                              valid_q, valid_d;
  fsm_e                              fsm_q, fsm_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic                              hs;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [63:0]        LANE_SALT64 = 64'(i) * RNG_SALT;
    localparam logic [STATE_W-1:0] LANE_SALT   = LANE_SALT64[STATE_W-1:0];
    localparam logic [STATE_W-1:0] RST_RAW     = SEED[STATE_W-1:0] ^ LANE_SALT;
    // A zero state is a fixed point of xorshift, so zero seeds become 1.
    localparam logic [STATE_W-1:0] RST_SEED    = (RST_RAW == '0) ? STATE_W'(1) : RST_RAW;

    logic [STATE_W-1:0] ld_raw;
    assign ld_raw        = seed_in ^ LANE_SALT;
    assign load_seed[i]  = (ld_raw == '0) ? STATE_W'(1) : ld_raw;
    assign reset_seed[i] = RST_SEED;

    xorshift_step #(.STATE_W(STATE_W)) u_step (
      .state_i (lane_q[i]),
      .next_o  (lane_nxt[i])
    );

    assign word_nxt[i] = lane_nxt[i][OUT_W-1:0];
  end

  assign hs = valid_q & out_ready;

  always_comb begin
    lane_d  = lane_q;
    rand_d  = rand_q;
    valid_d = valid_q;
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    // An accepted word is counted even when a reseed lands on the same edge.
    if (hs) cnt_d = cnt_q + 32'd1;
    if (seed_load) begin
      lane_d  = load_seed;
      valid_d = 1'b0;
      fsm_d   = FILL;
    end else if (fsm_q == FILL) begin
      if (en) begin
        lane_d  = lane_nxt;
        rand_d  = word_nxt;
        valid_d = 1'b1;
        fsm_d   = VALID;
      end
    end else if (hs) begin
      if (en) begin
        lane_d = lane_nxt;
        rand_d = word_nxt;
      end else begin
        valid_d = 1'b0;
        fsm_d   = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= reset_seed;
      rand_q  <= '0;
      valid_q <= 1'b0;
      fsm_q   <= FILL;
      cnt_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign rand_out  = rand_q;
  assign gen_count = cnt_q;

endmodule

// File: tb/tb_xorshift_rng_array.sv
// Directed table plus scoreboarded random-handshake streams for the xorshift array.
module tb_xorshift_rng_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 32-bit state, full-width output so the lane state is visible.
  logic         rst_a = 1'b1, en_a = 1'b0, ld_a = 1'b0, rdy_a = 1'b0;
  logic [31:0]  seed_a = '0;
  logic         v_a;
  logic [127:0] rand_a;
  logic [31:0]  cnt_a;

  // Instances B (16-bit, 2 lanes, 8-bit words) and C (64-bit) share controls.
  logic         rst_b = 1'b1, en_b = 1'b0, ld_b = 1'b0, rdy_b = 1'b0;
  logic [15:0]  seed_b = '0;
  logic [63:0]  seed_c = '0;
  logic         v_b, v_c;
  logic [15:0]  rand_b;
  logic [63:0]  rand_c;
  logic [31:0]  cnt_b, cnt_c;

  xorshift_rng_array #(.STATE_W(32), .OUT_W(32), .NUM_LANES(4), .SEED(64'h1)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .seed_load(ld_a), .seed_in(seed_a),
    .out_ready(rdy_a), .out_valid(v_a), .rand_out(rand_a), .gen_count(cnt_a));

  xorshift_rng_array #(.STATE_W(16), .OUT_W(8), .NUM_LANES(2), .SEED(64'hACE1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .seed_load(ld_b), .seed_in(seed_b),
    .out_ready(rdy_b), .out_valid(v_b), .rand_out(rand_b), .gen_count(cnt_b));

  xorshift_rng_array #(.STATE_W(64), .OUT_W(64), .NUM_LANES(1),
                       .SEED(64'h0123_4567_89AB_CDEF)) u_c (
    .clk(clk), .rst(rst_b), .en(en_b), .seed_load(ld_b), .seed_in(seed_c),
    .out_ready(rdy_b), .out_valid(v_c), .rand_out(rand_c), .gen_count(cnt_c));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m16(input logic [15:0] x);
    logic [15:0] y;
    y = x ^ (x << 7);
    y = y ^ (y >> 9);
    y = y ^ (y << 8);
    return y;
  endfunction

  function automatic logic [31:0] m32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [63:0] m64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [31:0] seed32(input int i);
    logic [31:0] s;
    s = 32'h1 ^ (32'(i) * 32'h7F4A_7C15);
    return (s == '0) ? 32'h1 : s;
  endfunction

  function automatic logic [15:0] seed16(input int i);
    logic [15:0] s;
    s = 16'hACE1 ^ (16'(i) * 16'h7C15);
    return (s == '0) ? 16'h1 : s;
  endfunction

  typedef struct {
    string       nm;
    logic        rst, en, ld, rdy;
    logic [31:0] seed;
    logic        ev;
    logic [31:0] er;
    logic [31:0] ec;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic rst, input logic en,
                              input logic ld, input logic rdy, input logic [31:0] seed,
                              input logic ev, input logic [31:0] er, input logic [31:0] ec);
    vec_t v;
    v.nm = nm; v.rst = rst; v.en = en; v.ld = ld; v.rdy = rdy; v.seed = seed;
    v.ev = ev; v.er = er; v.ec = ec;
    return v;
  endfunction

  vec_t tv[19];

  logic [31:0] ma[4];
  logic [15:0] mb[2];
  logic [63:0] mc;
  int          d_a, d_b, d_c;

  initial begin
    //          name        rst en ld rdy seed  valid rand lane0     count
    tv[0]  = mk("rst0",      1, 0, 0, 0, 32'h0, 0, 32'h0000_0000, 0);
    tv[1]  = mk("rst1",      1, 0, 0, 0, 32'h0, 0, 32'h0000_0000, 0);
    tv[2]  = mk("first",     0, 1, 0, 1, 32'h0, 1, 32'h0004_2021, 0);
    tv[3]  = mk("second",    0, 1, 0, 1, 32'h0, 1, 32'h0408_0601, 1);
    tv[4]  = mk("bp1",       0, 1, 0, 0, 32'h0, 1, 32'h0408_0601, 1);
    tv[5]  = mk("bp2",       0, 1, 0, 0, 32'h0, 1, 32'h0408_0601, 1);
    tv[6]  = mk("bp3",       0, 1, 0, 0, 32'h0, 1, 32'h0408_0601, 1);
    tv[7]  = mk("bp4",       0, 1, 0, 0, 32'h0, 1, 32'h0408_0601, 1);
    tv[8]  = mk("bp5",       0, 1, 0, 0, 32'h0, 1, 32'h0408_0601, 1);
    tv[9]  = mk("release",   0, 1, 0, 1, 32'h0, 1, 32'h9DCC_A8C5, 2);
    tv[10] = mk("hold_en0",  0, 0, 0, 0, 32'h0, 1, 32'h9DCC_A8C5, 2);
    tv[11] = mk("drain",     0, 0, 0, 1, 32'h0, 0, 32'h9DCC_A8C5, 3);
    tv[12] = mk("load0",     0, 1, 1, 0, 32'h0, 0, 32'h9DCC_A8C5, 3);
    tv[13] = mk("rl_first",  0, 1, 0, 1, 32'h0, 1, 32'h0004_2021, 3);
    tv[14] = mk("rl_second", 0, 1, 0, 1, 32'h0, 1, 32'h0408_0601, 4);
    tv[15] = mk("load_hs",   0, 1, 1, 1, 32'h0, 0, 32'h0408_0601, 5);
    tv[16] = mk("lh_first",  0, 1, 0, 1, 32'h0, 1, 32'h0004_2021, 5);
    tv[17] = mk("rst_ld",    1, 1, 1, 1, 32'h5, 0, 32'h0000_0000, 0);
    tv[18] = mk("rst_win",   0, 1, 0, 0, 32'h0, 1, 32'h0004_2021, 0);

    for (int k = 0; k < 19; k++) begin
      rst_a = tv[k].rst; en_a = tv[k].en; ld_a = tv[k].ld; rdy_a = tv[k].rdy;
      seed_a = tv[k].seed;
      @(posedge clk); #1;
      chk({tv[k].nm, "_valid"}, 128'(v_a), 128'(tv[k].ev));
      chk({tv[k].nm, "_rand"}, 128'(rand_a[31:0]), 128'(tv[k].er));
      chk({tv[k].nm, "_count"}, 128'(cnt_a), 128'(tv[k].ec));
    end
    chk("lane0_byte", 128'(rand_a[7:0]), 128'(8'h21));

    // Four-lane stream under random enable/backpressure against per-lane model.
    rst_a = 1'b1; en_a = 1'b0; ld_a = 1'b0; rdy_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) ma[i] = seed32(i);
    d_a = 0;
    for (int cyc = 0; cyc < 2000 && d_a < 100; cyc++) begin
      en_a  = 1'($urandom_range(0, 1));
      rdy_a = 1'($urandom_range(0, 1));
      if (v_a && rdy_a) begin
        for (int i = 0; i < 4; i++) begin
          ma[i] = m32(ma[i]);
          chk("a_lane_word", 128'(rand_a[i*32 +: 32]), 128'(ma[i]));
        end
        if (d_a == 0) begin
          for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++) begin
              n_chk++;
              if (rand_a[i*32 +: 32] == rand_a[j*32 +: 32]) begin
                n_fail++;
                $display("FAIL a_lanes_differ: lane %0d and %0d both %0h", i, j,
                         rand_a[i*32 +: 32]);
              end
            end
        end
        d_a++;
      end
      @(posedge clk); #1;
    end
    chk("a_words_delivered", 128'(d_a), 128'(100));
    chk("a_gen_count", 128'(cnt_a), 128'(d_a));

    // 16- and 64-bit streams, 1000 words each, random en and 50% ready.
    rst_b = 1'b1; en_b = 1'b0; ld_b = 1'b0; rdy_b = 1'b0;
    @(posedge clk); #1;
    chk("b_reset_valid", 128'(v_b), 128'(0));
    chk("c_reset_rand", 128'(rand_c), 128'(0));
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) mb[i] = seed16(i);
    mc = 64'h0123_4567_89AB_CDEF;
    d_b = 0; d_c = 0;
    for (int cyc = 0; cyc < 20000 && (d_b < 1000 || d_c < 1000); cyc++) begin
      en_b  = 1'($urandom_range(0, 1));
      rdy_b = 1'($urandom_range(0, 1));
      if (v_b && rdy_b) begin
        for (int i = 0; i < 2; i++) begin
          mb[i] = m16(mb[i]);
          chk("b_lane_word", 128'(rand_b[i*8 +: 8]), 128'(mb[i][7:0]));
        end
        d_b++;
      end
      if (v_c && rdy_b) begin
        mc = m64(mc);
        chk("c_word", 128'(rand_c), 128'(mc));
        d_c++;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (d_b < 1000 || d_c < 1000) begin
      n_fail++;
      $display("FAIL bc_budget: delivered b=%0d c=%0d required 1000 each", d_b, d_c);
    end
    chk("b_gen_count", 128'(cnt_b), 128'(d_b));
    chk("c_gen_count", 128'(cnt_c), 128'(d_c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
